// File: rtl/launch_controller.sv
// Turn-based firing controller: keeps per-player aim state, drives the launch/boomed
// handshake towards the bomb block and hands the turn over once the explosion settles.
`timescale 1ns/1ps
module launch_controller #(
    parameter int REPEAT_FRAMES  = 8,
    parameter int LAUNCH_TIMEOUT = 4,
    parameter int SETTLE_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic [9:0] tankX0,
    input  logic [9:0] tankY0,
    input  logic [9:0] tankX1,
    input  logic [9:0] tankY1,
    input  logic       boomed,
    output logic       launch,
    output logic [9:0] launchX,
    output logic [9:0] launchY,
    output logic [3:0] angle,
    output logic [2:0] power,
    output logic       player,
    output logic       aiming
);
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam int         CW        = 8;

    typedef enum logic [1:0] {AIM, FIRE, FLIGHT, SETTLE} state_t;

    state_t        state, state_nx;
    logic [7:0]    prev_key;
    logic [CW-1:0] repeat_cnt, repeat_nx;
    logic [CW-1:0] timeout_cnt, timeout_nx;
    logic [CW-1:0] settle_cnt, settle_nx;
    logic          launch_r, launch_nx;
    logic          player_r, player_nx;
    logic          space_lock;
    logic [3:0]    angle0, angle1, cur_angle, angle_nx;
    logic [2:0]    power0, power1, cur_power, power_nx;
    logic          press, aim_key, repeat_due, key_act, fire;

    assign cur_angle = player_r ? angle1 : angle0;
    assign cur_power = player_r ? power1 : power0;
    assign launch    = launch_r;
    assign player    = player_r;
    assign angle     = cur_angle;
    assign power     = cur_power;
    assign launchX   = player_r ? tankX1 : tankX0;
    assign launchY   = player_r ? tankY1 : tankY0;
    assign aiming    = (state == AIM);

    assign press      = (keycode != prev_key);
    assign aim_key    = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) ||
                        (keycode == KEY_UP)   || (keycode == KEY_DOWN);
    assign repeat_due = !press && (repeat_cnt + 8'd1 == CW'(REPEAT_FRAMES));
    assign key_act    = (state == AIM) && aim_key && (press || repeat_due);
    // space_lock keeps a space key held through reset from firing until it is released once
    assign fire       = (state == AIM) && press && (keycode == KEY_SPACE) && !space_lock;

    always_comb begin
        repeat_nx = '0;
        if (aim_key && !press && !repeat_due) repeat_nx = repeat_cnt + 8'd1;
    end

    always_comb begin
        angle_nx = cur_angle;
        power_nx = cur_power;
        if (key_act) begin
            case (keycode)
                KEY_LEFT:  if (cur_angle != 4'd0) angle_nx = cur_angle - 4'd1;
                KEY_RIGHT: if (cur_angle <  4'd8) angle_nx = cur_angle + 4'd1;
                KEY_UP:    if (cur_power != 3'd7) power_nx = cur_power + 3'd1;
                KEY_DOWN:  if (cur_power != 3'd0) power_nx = cur_power - 3'd1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        launch_nx  = launch_r;
        player_nx  = player_r;
        timeout_nx = timeout_cnt;
        settle_nx  = settle_cnt;
        case (state)
            AIM: begin
                if (fire) begin
                    launch_nx  = 1'b1;
                    timeout_nx = '0;
                    state_nx   = FIRE;
                end
            end
            FIRE: begin
                if (!boomed) begin
                    launch_nx = 1'b0;
                    state_nx  = FLIGHT;
                end else begin
                    timeout_nx = timeout_cnt + 8'd1;
                    if (timeout_cnt + 8'd1 == CW'(LAUNCH_TIMEOUT)) begin
                        launch_nx = 1'b0;
                        state_nx  = AIM;
                    end
                end
            end
            FLIGHT: begin
                if (boomed) begin
                    settle_nx = '0;
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                settle_nx = settle_cnt + 8'd1;
                if (settle_cnt + 8'd1 == CW'(SETTLE_FRAMES)) begin
                    player_nx = ~player_r;
                    state_nx  = AIM;
                end
            end
            default: state_nx = AIM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= AIM;
            launch_r    <= 1'b0;
            player_r    <= 1'b0;
            angle0      <= 4'd6;
            power0      <= 3'd3;
            angle1      <= 4'd2;
            power1      <= 3'd3;
            repeat_cnt  <= '0;
            timeout_cnt <= '0;
            settle_cnt  <= '0;
            prev_key    <= 8'h00;
            space_lock  <= 1'b1;
        end else if (frame_tick) begin
            state       <= state_nx;
            launch_r    <= launch_nx;
            player_r    <= player_nx;
            repeat_cnt  <= repeat_nx;
            timeout_cnt <= timeout_nx;
            settle_cnt  <= settle_nx;
            prev_key    <= keycode;
            space_lock  <= space_lock && (keycode == KEY_SPACE);
            if (player_r) begin
                angle1 <= angle_nx;
                power1 <= power_nx;
            end else begin
                angle0 <= angle_nx;
                power0 <= power_nx;
            end
        end
    end
endmodule

// File: doc/launch_controller.md
Name: launch_controller

Overview:
- Turn-based firing controller; the initiator side of the projectile's launch/boomed handshake.
- Holds the per-player aim state (angle 0..8, power 0..7) and adjusts it from USB keyboard keycodes.
- Fires by raising launch with the active player's tank position, waits for the bomb to arm, fly and explode, lets the explosion settle, then passes the turn to the other player.
- Sits between the keyboard interface and the bomb block; runs on clk with a frame_tick enable.

Parameters:
- REPEAT_FRAMES, 8: frame ticks between auto-repeat steps while an aim key is held.
- LAUNCH_TIMEOUT, 4: frame ticks to wait for boomed to fall after launch rises.
- SETTLE_FRAMES, 30: frame ticks after boomed rises before the turn passes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame (same cadence as frame_clk)
- keycode  in  8  current USB HID keycode, 0 = none
- tankX0, tankY0  in  10 each  player 0 tank position
- tankX1, tankY1  in  10 each  player 1 tank position
- boomed  in  1  bomb status: 1 = inactive/exploded, 0 = in flight
- launch  out  1  launch request to bomb
- launchX, launchY  out  10 each  active tank position
- angle  out  4  active player angle, 0 = horizontal left, 4 = straight up, 8 = horizontal right
- power  out  3  active player power
- player  out  1  active player
- aiming  out  1  high in AIM state

Behaviour:
- Reset: asynchronous, active-high, may occur in any state including mid-flight.
  - Goes to AIM with player=0 and launch=0.
  - Player 0: angle=6, power=3. Player 1: angle=2, power=3.
  - Repeat counter, timeout counter and settle counter = 0; prev_key=0x00.
- Combinational outputs:
  - launchX/launchY = active player's tankX/tankY.
  - angle/power = active player's registers.
  - aiming = (state==AIM).
- All state changes other than reset happen only on clk edges where frame_tick=1. On non-tick cycles all registers hold.
- Key decode, sampled on frame_tick:
  - press = keycode != prev_key; prev_key <= keycode every tick.
  - An aim key acts on a press and resets repeat_cnt to 0.
  - While the same aim key stays held, repeat_cnt increments each tick. When it reaches REPEAT_FRAMES the key acts again and repeat_cnt resets to 0.
- Key actions (AIM state only; ignored in every other state):
  - 0x50 left arrow: angle-1, saturating at 0.
  - 0x4F right arrow: angle+1, saturating at 8.
  - 0x52 up arrow: power+1, saturating at 7.
  - 0x51 down arrow: power-1, saturating at 0.
  - 0x2C space: fire on press only, no auto-repeat. Holding space across turns does not re-fire.
  - Any other code: no action.
- FSM: AIM -> FIRE -> FLIGHT -> SETTLE -> AIM.
  - AIM: a space press sets launch=1, clears timeout_cnt, moves to FIRE.
  - FIRE: launch held at 1; at each tick:
    - boomed=0: launch<=0, go to FLIGHT.
    - else timeout_cnt++; when it reaches LAUNCH_TIMEOUT: launch<=0, return to AIM with the same player.
  - FLIGHT: at the first tick with boomed=1, clear settle_cnt and go to SETTLE.
  - SETTLE: settle_cnt++ per tick; when it reaches SETTLE_FRAMES: player<=~player, go to AIM.
- The angle/power/player values captured by the bomb are those present while launch=1. Aim registers cannot change outside AIM, so they are stable for the whole launch window.
- A key press in the same tick as an FSM transition is evaluated against the state before the transition.
- Tank position inputs may change at any time; launchX/launchY follow them without registering.

Test Plan:
- Reset, no keys -> player=0, angle=6, power=3, launch=0, aiming=1. Switch to player 1 via a full turn -> angle=2, power=3.
- Hold 0x4F for 20 ticks from angle 6 -> +1 on the first tick, +1 at tick 9 reaching 8, saturates at 8. Hold 0x51 from power 3 for 40 ticks -> power 0, no wrap to 7.
- Press 0x2C, model boomed drops 2 ticks later -> launch high for exactly those 2 ticks then 0, state FLIGHT. Left-arrow presses during FLIGHT leave angle unchanged.
- Boomed rises in FLIGHT -> 30 ticks later player toggles to 1, aiming=1, launchX/launchY = tankX1/tankY1, angle=2.
- Press space with boomed held at 1 -> launch high for 4 ticks, then 0, back in AIM, player still 0.
- Assert reset during FLIGHT with player=1 -> immediately launch=0, player=0, aiming=1, angles restored to reset values. Keycode 0x2C held through reset release -> no fire until released and pressed again.
